bin2bcd_seq: RTL and testbench
==============================

# bin2bcd_seq

Sequential binary-to-BCD converter (shift-and-add-3, "double dabble") that sits directly upstream of the seven-segment display driver. It accepts a binary count (0–9999 for the default 4-digit display), converts it over a fixed number of cycles, and presents a registered packed-BCD word that the display driver multiplexes onto the digits. A one-cycle `done` pulse marks each update. Between conversions the output holds steady, so the display never sees intermediate values.

## Interface
- `BIN_W`, default 14: binary input width. Must satisfy 2^BIN_W ≥ 10^DIGITS.
- `DIGITS`, default 4: number of BCD digits. BCD output width is 4*DIGITS.
- `clk`, input, 1: single clock. All logic is on the rising edge.
- `reset`, input, 1: synchronous, active-low reset, sampled on `clk`.
- `start`, input, 1: request a conversion. Honoured only in IDLE.
- `bin`, input, BIN_W: binary value, captured on the accepted `start` edge.
- `busy`, output, 1: high while a conversion is in progress.
- `done`, output, 1: one-cycle pulse when `bcd` and `overflow` update.
- `bcd`, output, 4*DIGITS: packed BCD, most significant digit in the top nibble. Feeds the display driver's `bcd` input.
- `overflow`, output, 1: last captured `bin` exceeded 10^DIGITS−1.

## Operation
- States:
  - IDLE: waits for `start`.
  - SHIFT: performs BIN_W adjust-and-shift steps.
- IDLE→SHIFT when `start`=1 at a rising edge. On that edge:
  - load the working shift register: upper 4*DIGITS bits = 0, lower BIN_W bits = `bin`;
  - clear the step counter;
  - set `busy`;
  - latch `ovf_pending` = (`bin` > 10^DIGITS−1).
- Each SHIFT step:
  - every BCD nibble of the working register that is ≥5 gets +3, all nibbles evaluated in parallel;
  - then the whole register shifts left by 1.
- The step counter runs 0..BIN_W−1. On the step with counter = BIN_W−1, all of the following happen on that edge:
  - `bcd` ← result nibbles, or all nibbles 4'h9 if `ovf_pending`;
  - `overflow` ← `ovf_pending`;
  - `done` ← 1;
  - `busy` ← 0;
  - state ← IDLE.
- Overflow conversions still run the full BIN_W steps, so latency is uniform.
- `done` is high for exactly one cycle. `bcd` and `overflow` hold until the next `done`.
- `start` during SHIFT is ignored. It is not queued.
- Reset (`reset`=0 at an edge) forces:
  - state IDLE;
  - `busy`=0, `done`=0, `overflow`=0;
  - `bcd`=0, which the display shows as 0000;
  - working register and counter cleared.
- Reset mid-conversion aborts the conversion. No `done` is produced.
- Reset has priority over `start` on the same edge.

## Timing
- `start` accepted at edge k.
  - `busy`=1 from after edge k until edge k+BIN_W.
  - `bcd`, `overflow` and `done` update at edge k+BIN_W. That is 14 cycles by default.
- `done` is high during the cycle between edges k+BIN_W and k+BIN_W+1.
- Back-to-back conversions:
  - `start` held or asserted during the `done` cycle is accepted at edge k+BIN_W+1, since state is IDLE;
  - maximum throughput is one conversion per BIN_W+1 cycles.
- `bin` only needs to be valid at the accepting edge. Later changes to `bin` have no effect.
- `bcd` never changes except on a `done` edge or reset. This is glitch-free for the downstream multiplexed display.

## Structure
- Shared package `bin2bcd_pkg` holds:
  - the state enum (IDLE, SHIFT);
  - default constants BIN_W=14 and DIGITS=4;
  - constant MAX_VAL = 10^DIGITS−1;
  - the all-nines saturation pattern.
- One sub-module is natural: `bcd_add3`. It is a combinational 4-bit nibble adjust (in ≥5 → in+3, else in), instantiated DIGITS times in a generate loop.
- Counter width is $clog2(BIN_W).

## Test plan
- Reset then idle, no `start` → `bcd`=16'h0000, `busy`=0, `done`=0, `overflow`=0 for all cycles.
- `bin`=1234 with `start` at edge k → `busy` high for 14 cycles; at edge k+14: `bcd`=16'h1234, `done` pulses 1 cycle, `overflow`=0.
- `bin`=0, then 9999, then 10000, each started during the previous conversion's `done` cycle:
  - `bcd`=16'h0000, then 16'h9999 with `overflow`=0;
  - then 16'h9999 with `overflow`=1;
  - `done` edges spaced exactly 15 cycles apart.
- `bin`=16383 → `bcd`=16'h9999, `overflow`=1. A following `bin`=42 → `bcd`=16'h0042, `overflow`=0.
- `start` pulsed with `bin`=5678 at cycle 5 of a conversion of 321 → pulse ignored; result 16'h0321; no second `done`.
- `reset` low at cycle 7 of converting 8765 → `busy`=0 and `bcd`=16'h0000 next cycle; no `done`. A fresh `start` with 8765 then yields 16'h8765 after 14 cycles.

Source files
------------

// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Holds the FSM state enum, default sizing and the saturation pattern.
package bin2bcd_pkg;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    localparam int DEF_BIN_W  = 14;
    localparam int DEF_DIGITS = 4;

    // Integer power of ten, used to derive the largest displayable value.
    function automatic int unsigned pow10(input int n);
        int unsigned p;
        p = 1;
        for (int i = 0; i < n; i++) begin
            p = p * 10;
        end
        return p;
    endfunction

    localparam int unsigned MAX_VAL = pow10(DEF_DIGITS) - 1;

    localparam logic [4*DEF_DIGITS-1:0] ALL_NINES = {DEF_DIGITS{4'h9}};

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble adjust: values of 5..15 get +3, others pass through.
// Ports: value (4-bit BCD nibble in), result (adjusted nibble out).
module bcd_add3 (
    input  logic [3:0] value,
    output logic [3:0] result
);

    assign result = (value >= 4'd5) ? value + 4'd3 : value;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter feeding the display.
// Ports: clk, reset (sync, active-low), start, bin -> busy, done, bcd, overflow.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W  = DEF_BIN_W,
    parameter int DIGITS = DEF_DIGITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int W     = BCD_W + BIN_W;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    localparam logic [CNT_W-1:0] LAST  = CNT_W'(BIN_W - 1);
    localparam int unsigned      LIMIT = pow10(DIGITS) - 1;
    localparam logic [BCD_W-1:0] NINES = {DIGITS{4'h9}};

    state_t           state;
    logic [W-1:0]     work;
    logic [W-1:0]     adj;
    logic [W-1:0]     shifted;
    logic [CNT_W-1:0] cnt;
    logic             ovf_pending;

    // Only the BCD nibbles are adjusted; the binary tail passes through.
    assign adj[BIN_W-1:0] = work[BIN_W-1:0];

    for (genvar d = 0; d < DIGITS; d++) begin : g_adj
        bcd_add3 u_add3 (
            .value  (work[BIN_W+4*d +: 4]),
            .result (adj[BIN_W+4*d +: 4])
        );
    end

    assign shifted = {adj[W-2:0], 1'b0};

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            work        <= '0;
            cnt         <= '0;
            ovf_pending <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            bcd         <= '0;
            overflow    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        work        <= {{BCD_W{1'b0}}, bin};
                        cnt         <= '0;
                        busy        <= 1'b1;
                        ovf_pending <= (32'(bin) > LIMIT);
                        state       <= SHIFT;
                    end
                end
                SHIFT: begin
                    work <= shifted;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        // Final shift lands the result; out-of-range inputs saturate.
                        bcd      <= ovf_pending ? NINES : shifted[W-1 -: BCD_W];
                        overflow <= ovf_pending;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq.
// Table of conversions run back-to-back plus hand-written corner sequences.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [13:0] bin = '0;
    logic        busy;
    logic        done;
    logic [15:0] bcd;
    logic        overflow;

    bin2bcd_seq dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bin      (bin),
        .busy     (busy),
        .done     (done),
        .bcd      (bcd),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_done = -1;
    logic [15:0] last_exp = '0;

    always @(posedge clk) cyc++;

    typedef struct {
        logic [13:0] bin;
        logic [15:0] bcd;
        logic        ovf;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts a conversion at the next edge and waits (bounded) for done.
    task automatic convert(input logic [13:0] v, input logic [15:0] eb,
                           input logic eo, input bit b2b);
        int n;
        bit held;
        bin = v;
        start = 1'b1;
        step();
        start = 1'b0;
        bin = 14'h3fff;
        chk("busy_after_start", 32'(busy), 32'd1);
        n = 0;
        held = 1'b1;
        while (!done && n < 40) begin
            if (bcd !== last_exp) held = 1'b0;
            step();
            n++;
        end
        chk("latency", 32'(n), 32'd14);
        chk("bcd", 32'(bcd), 32'(eb));
        chk("overflow", 32'(overflow), 32'(eo));
        chk("busy_at_done", 32'(busy), 32'd0);
        chk("bcd_held", 32'(held), 32'd1);
        if (b2b && last_done >= 0)
            chk("done_spacing", 32'(cyc - last_done), 32'd15);
        last_done = cyc;
        last_exp = eb;
    endtask

    task automatic no_done_for(input int n, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            step();
            if (done) seen = 1'b1;
        end
        chk(name, 32'(seen), 32'd0);
    endtask

    initial begin
        vecs[0]  = '{14'd0,     16'h0000, 1'b0};
        vecs[1]  = '{14'd9999,  16'h9999, 1'b0};
        vecs[2]  = '{14'd10000, 16'h9999, 1'b1};
        vecs[3]  = '{14'd16383, 16'h9999, 1'b1};
        vecs[4]  = '{14'd42,    16'h0042, 1'b0};
        vecs[5]  = '{14'd1,     16'h0001, 1'b0};
        vecs[6]  = '{14'd10,    16'h0010, 1'b0};
        vecs[7]  = '{14'd99,    16'h0099, 1'b0};
        vecs[8]  = '{14'd100,   16'h0100, 1'b0};
        vecs[9]  = '{14'd5000,  16'h5000, 1'b0};
        vecs[10] = '{14'd4095,  16'h4095, 1'b0};
        vecs[11] = '{14'd9998,  16'h9998, 1'b0};

        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("idle_bcd", 32'(bcd), 32'h0);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_done", 32'(done), 32'd0);
            chk("idle_ovf", 32'(overflow), 32'd0);
        end

        convert(14'd1234, 16'h1234, 1'b0, 1'b0);
        step();
        chk("done_width", 32'(done), 32'd0);
        chk("bcd_after_done", 32'(bcd), 32'h1234);

        // Each new start is issued in the previous done cycle.
        for (int i = 0; i < 12; i++) begin
            convert(vecs[i].bin, vecs[i].bcd, vecs[i].ovf, i > 0);
        end
        step();
        chk("done_width_b2b", 32'(done), 32'd0);

        // Start pulse during an active conversion must be ignored.
        bin = 14'd321;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        bin = 14'd5678;
        start = 1'b1;
        step();
        start = 1'b0;
        bin = '0;
        begin
            int n;
            n = 5;
            while (!done && n < 40) begin
                step();
                n++;
            end
            chk("ign_latency", 32'(n), 32'd14);
        end
        chk("ign_bcd", 32'(bcd), 32'h0321);
        chk("ign_ovf", 32'(overflow), 32'd0);
        last_exp = 16'h0321;
        no_done_for(20, "ign_no_second_done");
        chk("ign_busy_idle", 32'(busy), 32'd0);

        // Reset mid-conversion aborts without a done.
        bin = 14'd8765;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 6; i++) step();
        reset = 1'b0;
        start = 1'b1;
        step();
        reset = 1'b1;
        start = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_bcd", 32'(bcd), 32'h0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        last_exp = 16'h0000;
        no_done_for(20, "rst_no_done");
        convert(14'd8765, 16'h8765, 1'b0, 1'b0);
        step();
        chk("final_done_low", 32'(done), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
